// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC engine.
package crc_pkg;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam int unsigned DEFAULT_DATA_W   = 34;
    localparam int unsigned DEFAULT_CRC_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit MSB-first CRC update: fb = crc[MSB] ^ bit; crc = (crc << 1) ^ (fb ? POLY : 0).
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int unsigned          CRC_W = DEFAULT_CRC_W,
    parameter logic [CRC_W-1:0]     POLY  = CRC_W'(CRC16_CCITT_POLY)
) (
    input  logic [CRC_W-1:0] crc_cur,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_next_c
);

    logic fb;

    always_comb begin
        fb         = crc_cur[CRC_W-1] ^ bit_in;
        crc_next_c = (crc_cur << 1) ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker: IDLE -> SHIFT (DATA_W cycles) -> DONE -> IDLE.
// Check mode is compiled in only when CRC_SERIAL_CHECK_EN is defined.
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_W = DEFAULT_DATA_W,
    parameter int unsigned      CRC_W  = DEFAULT_CRC_W,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    mode,
    input  logic [CRC_W-1:0]        crc_in,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W+CRC_W-1:0] data_out,
    output logic                    crc_ok
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    crc_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CRC_W-1:0]         crc_q, crc_d;
    logic [DATA_W-1:0]        sh_q, sh_d;
    logic                     mode_q, mode_d;
    logic [CRC_W-1:0]         crc_in_q, crc_in_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [DATA_W+CRC_W-1:0]  data_out_q, data_out_d;
    logic                     crc_ok_q, crc_ok_d;

    logic                     chk_mode_c;
    logic [CRC_W-1:0]         chk_crc_c;
    logic [CRC_W-1:0]         crc_next_c;
    logic [DATA_W-1:0]        sh_rot_c;

`ifdef CRC_SERIAL_CHECK_EN
    assign chk_mode_c = mode;
    assign chk_crc_c  = crc_in;
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode, crc_in};
    assign chk_mode_c = 1'b0;
    assign chk_crc_c  = '0;
`endif

    // Payload is rotated rather than shifted out, so after DATA_W steps it is intact again.
    assign sh_rot_c = (sh_q << 1) | (sh_q >> (DATA_W - 1));

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_cur    (crc_q),
        .bit_in     (sh_q[DATA_W-1]),
        .crc_next_c (crc_next_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        sh_d       = sh_q;
        mode_d     = mode_q;
        crc_in_d   = crc_in_q;
        data_out_d = data_out_q;
        crc_ok_d   = crc_ok_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    sh_d     = data_in;
                    mode_d   = chk_mode_c;
                    crc_in_d = chk_crc_c;
                    crc_d    = INIT;
                    cnt_d    = CNT_W'(DATA_W - 1);
                end
            end
            ST_SHIFT: begin
                crc_d = crc_next_c;
                sh_d  = sh_rot_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                    data_out_d = {sh_rot_c, crc_next_c};
                    crc_ok_d   = mode_q & (crc_next_c == crc_in_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            crc_q      <= INIT;
            sh_q       <= '0;
            mode_q     <= 1'b0;
            crc_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            sh_q       <= sh_d;
            mode_q     <= mode_d;
            crc_in_q   <= crc_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign crc_ok   = crc_ok_q;

endmodule

// File: doc/crc_serial_engine.md
CRC_SERIAL_ENGINE -- requirements
Module: crc_serial_engine

Interface
REQ-001 Parameter DATA_W, default 34: payload width in bits; legal range 1..256.
REQ-002 Parameter CRC_W, default 16: CRC width in bits; legal range 4..32.
REQ-003 Parameter POLY, default 16'h1021: generator polynomial, implicit x^CRC_W term omitted.
REQ-004 Parameter INIT, default 0: CRC register value loaded at frame start.
REQ-005 clk  input  1: single clock; all state updates on the rising edge.
REQ-006 reset  input  1: reset, asynchronous, active-low.
REQ-007 start  input  1: request to begin a frame; sampled only in IDLE.
REQ-008 data_in  input  DATA_W: payload; captured on the accepted start edge.
REQ-009 mode  input  1: captured with start; 0 = generate, 1 = check.
REQ-010 crc_in  input  CRC_W: expected CRC for check mode; captured with start.
REQ-011 busy  output  1: high while a frame is in progress (SHIFT or DONE).
REQ-012 done  output  1: single-cycle completion pulse.
REQ-013 data_out  output  DATA_W+CRC_W: {payload, computed CRC}; payload is the MSB part.
REQ-014 crc_ok  output  1: check-mode result; valid while done is high, held afterwards.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE.
REQ-016 Transitions: IDLE->SHIFT on start; SHIFT->DONE after exactly DATA_W shift cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 Accepted start: payload, mode and crc_in are latched, the CRC register loads INIT, and the bit counter loads DATA_W-1.
REQ-018 SHIFT: one payload bit per cycle, MSB first; fb = crc[CRC_W-1] ^ bit; crc = (crc<<1) ^ (fb ? POLY : 0); no reflection, no final XOR.
REQ-019 Latency: with start sampled at edge 0, done is high for exactly the cycle following edge DATA_W+1.
REQ-020 data_out and crc_ok update on the edge that enters DONE and hold until the next completion.
REQ-021 Check mode: crc_ok = (computed CRC == latched crc_in). Generate mode: crc_ok = 0.
REQ-022 start asserted while busy is ignored; no queuing, and latched inputs are unaffected.
REQ-023 start held high continuously: a new frame is accepted on the first IDLE cycle after DONE, giving a back-to-back period of DATA_W+2 cycles.
REQ-024 Changes on data_in, mode or crc_in after acceptance have no effect on the current frame.

Reset
REQ-025 reset low SHALL asynchronously force IDLE, busy=0, done=0, data_out=0, crc_ok=0, CRC register=INIT, counter=0.
REQ-026 Reset asserted mid-frame aborts the frame: no done pulse, and data_out is cleared.
REQ-027 After reset deasserts, the first rising edge with start=1 is accepted.

Configuration
REQ-028 Macro CRC_SERIAL_CHECK_EN defined: check mode operates per REQ-021.
REQ-029 Macro CRC_SERIAL_CHECK_EN undefined: the mode and crc_in ports remain present but are ignored; the block always generates and crc_ok is tied to 0.

Structure
REQ-030 Shared package crc_pkg SHALL hold the FSM state typedef plus constants CRC16_CCITT_POLY = 16'h1021 and the default widths.
REQ-031 One sub-module, crc_lfsr_step, SHALL implement the combinational one-bit update of REQ-018, parametrised by CRC_W and POLY.
REQ-032 Counter width SHALL be $clog2(DATA_W)+1.

Verification
REQ-033 DATA_W=8, generate, data_in=8'h01 -> done pulse 9 cycles after the start edge, data_out=24'h01_1021.
REQ-034 DATA_W=72, generate, data_in = ASCII "123456789" -> CRC field = 16'h31C3.
REQ-035 Check mode (macro defined), DATA_W=8, data 8'h01: crc_in=16'h1021 -> crc_ok=1; crc_in=16'h1020 -> crc_ok=0.
REQ-036 Default parameters, data_in=34'h0 -> data_out=50'h0; start re-pulsed while busy -> exactly one done pulse.
REQ-037 reset driven low at shift cycle 10 of a 34-bit frame -> busy=0, data_out=0 immediately, no done pulse; next start completes normally.
REQ-038 start held high for 3 frames, DATA_W=8 -> done pulses spaced exactly 10 cycles apart, each with the correct CRC.
